divider_8b: RTL and testbench
=============================

# divider_8b

Sequential 8-bit unsigned restoring divider for the lab board datapath; the inverse of the shift-add multiplier. Dividend loaded from switches into the quotient register; divisor sampled from switches at Run; eight shift/trial-subtract/restore iterations yield quotient and remainder. Results drive four hex digits and are exported for the bench.

## Interface
Parameters:
- N, 8, operand width; only 8 is supported on the board build.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high; clears all state.
- Run  in  1  active-high level, already debounced and inverted at top level; starts a divide.
- Load  in  1  active-high; in IDLE loads dividend Qval <= SW.
- SW  in  8  switch operand bus: dividend on Load, divisor on Run.
- Qval  out  8  quotient register; holds dividend before the run.
- Aval  out  8  remainder, the low 8 bits of the 9-bit A register.
- Busy  out  1  high while iterating.
- Done  out  1  high in DONE.
- Div_Zero  out  1  divisor sampled at Run was zero; valid with Done.
- HEX0..HEX3  out  7 each  active-low segments: Qval[3:0], Qval[7:4], Aval[3:0], Aval[7:4].

## Operation
- Registers: A (9 bits, signed trial), Q (8), D (8 divisor), cnt (3 bits), state.
- FSM states: IDLE, ITER, DONE.
- IDLE: Load=1 -> Q <= SW. Run=1 (priority over Load) -> A <= 0, D <= SW, cnt <= 0, Div_Zero <= (SW==0), state <= ITER.
- ITER, per cycle: T = {A[7:0], Q[7]} - {1'b0, D}, 9-bit. If T[8]==0: A <= T, Q <= {Q[6:0],1}; else A <= {A[7:0],Q[7]} (restore), Q <= {Q[6:0],0}. cnt++; when cnt==7 the state becomes DONE.
- DONE: hold Q, A, Div_Zero. Run==0 -> IDLE. Run held high does not restart.
- Divisor zero: iterations run unchanged and produce Q=8'hFF, A=dividend. Only the flag is special.
- Load, SW changes and Run edges during ITER/DONE are ignored; D is latched, so SW may change freely mid-divide.
- A new divide from IDLE uses the current Q (the previous quotient) unless Load occurs first.

## Timing
- Reset, either at power-on or mid-operation: next edge gives state=IDLE, A=Q=D=cnt=0, Busy=Done=Div_Zero=0, all HEX show "0" (7'b1000000).
- Run sampled high in IDLE at edge k: Busy=1 from k to k+8. Iterations occur at edges k+1..k+8. Done=1 after edge k+8. Total latency is 9 cycles.
- Busy = (state==ITER). Done = (state==DONE). Both are Moore outputs with no combinational path from inputs.
- Run released while in ITER: the divide completes. DONE is exited on the first edge after it is entered at which Run==0.
- HEX outputs are combinational from Qval/Aval.

## Structure
- Package div_pkg: state enum (IDLE, ITER, DONE), N, ITER_COUNT=8, hex blank/zero segment constants.
- Sub-module div_control: the FSM and cnt, with outputs for load_q, start, iterate, Busy and Done. The datapath (A/Q/D and trial subtractor) stays in divider_8b.
- Reuse the existing HexDriver for the four digits.

## Test plan
- Load 8'd100, Run with SW=8'd7 -> after 9 cycles Done=1, Qval=8'h0E, Aval=8'h02, Div_Zero=0, HEX1..0="0E".
- Load 8'hFF, divisor 8'h01 -> Qval=8'hFF, Aval=8'h00. Then divisor 8'hFF on a freshly loaded 8'hFF -> Qval=8'h01, Aval=0.
- Load 8'd5, divisor 8'd9 -> Qval=0, Aval=5.
- Load 8'hC8, divisor 0 -> Div_Zero=1, Qval=8'hFF, Aval=8'hC8, with the same 9-cycle latency.
- Reset asserted after the 4th iteration -> next cycle Busy=0, Qval=Aval=0, IDLE. A subsequent Load/Run gives a correct result.
- Run held high for 30 cycles -> exactly one divide and Done stays high. Toggling SW/Load during ITER does not change the result. Run low, then high again, starts a second divide.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the 8-bit restoring divider.
// Contents: FSM state enum, operand width, iteration count, 7-segment constants.
// Imported by the control FSM, the hex digit driver and the divider top.
package div_pkg;

    localparam int N          = 8;
    localparam int ITER_COUNT = 8;

    // Active-low segment patterns
    localparam logic [6:0] HEX_BLANK = 7'b1111111;
    localparam logic [6:0] HEX_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_control.sv
// div_control: IDLE/ITER/DONE sequencer and iteration counter for the divider.
// Ports: clk, reset (sync, active-high), run, load in; load_q, start, iterate,
//        busy, done out. All outputs depend on state and registered-free decode only.
module div_control
    import div_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic load,
    output logic load_q,
    output logic start,
    output logic iterate,
    output logic busy,
    output logic done
);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_q    = 1'b0;
        start     = 1'b0;
        iterate   = 1'b0;
        busy      = (state == ITER);
        done      = (state == DONE);
        case (state)
            IDLE: begin
                // Run wins over Load when both are asserted
                if (run) begin
                    start     = 1'b1;
                    cnt_nxt   = 3'd0;
                    state_nxt = ITER;
                end else if (load) begin
                    load_q = 1'b1;
                end
            end
            ITER: begin
                iterate = 1'b1;
                cnt_nxt = cnt + 3'd1;
                if (cnt == 3'(ITER_COUNT - 1))
                    state_nxt = DONE;
            end
            DONE: begin
                // Holding Run high parks here; a fresh divide needs Run low first
                if (!run)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/hex_driver.sv
// HexDriver: one nibble to one active-low 7-segment digit, purely combinational.
// Ports: in_nib (4-bit value), out_seg (segments g..a, low = lit).
// No clock, no state.
module HexDriver
    import div_pkg::*;
(
    input  logic [3:0] in_nib,
    output logic [6:0] out_seg
);

    always_comb begin
        out_seg = HEX_BLANK;
        case (in_nib)
            4'h0: out_seg = HEX_ZERO;
            4'h1: out_seg = 7'b1111001;
            4'h2: out_seg = 7'b0100100;
            4'h3: out_seg = 7'b0110000;
            4'h4: out_seg = 7'b0011001;
            4'h5: out_seg = 7'b0010010;
            4'h6: out_seg = 7'b0000010;
            4'h7: out_seg = 7'b1111000;
            4'h8: out_seg = 7'b0000000;
            4'h9: out_seg = 7'b0010000;
            4'hA: out_seg = 7'b0001000;
            4'hB: out_seg = 7'b0000011;
            4'hC: out_seg = 7'b1000110;
            4'hD: out_seg = 7'b0100001;
            4'hE: out_seg = 7'b0000110;
            4'hF: out_seg = 7'b0001110;
            default: out_seg = HEX_BLANK;
        endcase
    end

endmodule

// File: rtl/divider_8b.sv
// divider_8b: sequential unsigned restoring divider, dividend in Q, divisor latched at Run.
// Ports: Clk, Reset, Run, Load, SW in; Qval (quotient), Aval (remainder), Busy, Done,
//        Div_Zero, HEX0..HEX3 (Qval lo/hi, Aval lo/hi) out. Result 9 cycles after Run.
module divider_8b
    import div_pkg::*;
#(
    parameter int WIDTH = N
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Load,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Qval,
    output logic [WIDTH-1:0] Aval,
    output logic             Busy,
    output logic             Done,
    output logic             Div_Zero,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);

    logic load_q, start, iterate;

    // Partial remainder. Between iterations it is always below the divisor, so
    // its ninth bit is zero and only the trial difference needs to carry it.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic             dz_reg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    div_control u_ctrl (
        .clk     (Clk),
        .reset   (Reset),
        .run     (Run),
        .load    (Load),
        .load_q  (load_q),
        .start   (start),
        .iterate (iterate),
        .busy    (Busy),
        .done    (Done)
    );

    assign shifted = {a_reg, q_reg[WIDTH-1]};
    assign trial   = shifted - {1'b0, d_reg};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_reg  <= '0;
            q_reg  <= '0;
            d_reg  <= '0;
            dz_reg <= 1'b0;
        end else if (start) begin
            a_reg  <= '0;
            d_reg  <= SW;
            dz_reg <= (SW == '0);
        end else if (load_q) begin
            q_reg <= SW;
        end else if (iterate) begin
            // Negative trial means the divisor did not fit: keep the shifted value
            if (!trial[WIDTH]) begin
                a_reg <= trial[WIDTH-1:0];
                q_reg <= {q_reg[WIDTH-2:0], 1'b1};
            end else begin
                a_reg <= shifted[WIDTH-1:0];
                q_reg <= {q_reg[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign Qval     = q_reg;
    assign Aval     = a_reg;
    assign Div_Zero = dz_reg;

    HexDriver u_hex0 (.in_nib(q_reg[3:0]), .out_seg(HEX0));
    HexDriver u_hex1 (.in_nib(q_reg[7:4]), .out_seg(HEX1));
    HexDriver u_hex2 (.in_nib(a_reg[3:0]), .out_seg(HEX2));
    HexDriver u_hex3 (.in_nib(a_reg[7:4]), .out_seg(HEX3));

endmodule

// File: tb/tb_divider_8b.sv
// tb_divider_8b: directed-vector bench for divider_8b with hand-computed results.
// Drives inputs 1 time unit after the rising edge and samples there too.
// Prints one summary line and finishes.
module tb_divider_8b;

    logic       Clk = 1'b0;
    logic       Reset, Run, Load;
    logic [7:0] SW;
    logic [7:0] Qval, Aval;
    logic       Busy, Done, Div_Zero;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_E = 7'b0000110;

    divider_8b dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Run      (Run),
        .Load     (Load),
        .SW       (SW),
        .Qval     (Qval),
        .Aval     (Aval),
        .Busy     (Busy),
        .Done     (Done),
        .Div_Zero (Div_Zero),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Full divide: load dividend, run, verify 9-cycle latency and results, release Run.
    task automatic do_div(input string tag, input logic [7:0] dividend, input logic [7:0] divisor,
                          input logic [7:0] exp_q, input logic [7:0] exp_a, input logic exp_dz);
        Load = 1'b1; SW = dividend;
        step();
        check({tag, "_loaded"}, Qval, dividend);
        Load = 1'b0; Run = 1'b1; SW = divisor;
        step();                          // edge k
        check({tag, "_busy_k"}, Busy, 1'b1);
        repeat (7) step();               // edge k+7
        check({tag, "_busy_k7"}, Busy, 1'b1);
        check({tag, "_notdone_k7"}, Done, 1'b0);
        step();                          // edge k+8
        check({tag, "_done"}, Done, 1'b1);
        check({tag, "_busy_end"}, Busy, 1'b0);
        check({tag, "_q"}, Qval, exp_q);
        check({tag, "_a"}, Aval, exp_a);
        check({tag, "_dz"}, Div_Zero, exp_dz);
        Run = 1'b0;
        step();
        check({tag, "_idle"}, Done, 1'b0);
        check({tag, "_q_hold"}, Qval, exp_q);
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; Load = 1'b0; SW = 8'h00;
        step();
        step();
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_dz",   Div_Zero, 1'b0);
        check("rst_q",    Qval, 8'h00);
        check("rst_a",    Aval, 8'h00);
        check("rst_hex0", HEX0, SEG_0);
        check("rst_hex3", HEX3, SEG_0);
        Reset = 1'b0;
        step();

        // 100 / 7 = 14 r 2
        do_div("d100_7", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0);
        check("hex0_E", HEX0, SEG_E);
        check("hex1_0", HEX1, SEG_0);
        check("hex2_2", HEX2, SEG_2);
        check("hex3_0", HEX3, SEG_0);

        do_div("dFF_1",  8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0);
        do_div("dFF_FF", 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0);
        do_div("d5_9",   8'd5,  8'd9,  8'h00, 8'h05, 1'b0);
        do_div("dC8_0",  8'hC8, 8'h00, 8'hFF, 8'hC8, 1'b1);

        // Reset after the 4th iteration
        Load = 1'b1; SW = 8'd100;
        step();
        Load = 1'b0; Run = 1'b1; SW = 8'd7;
        step();                          // edge k
        repeat (4) step();               // edges k+1..k+4
        check("mid_busy_pre", Busy, 1'b1);
        Reset = 1'b1;
        step();
        check("mid_rst_busy", Busy, 1'b0);
        check("mid_rst_done", Done, 1'b0);
        check("mid_rst_q",    Qval, 8'h00);
        check("mid_rst_a",    Aval, 8'h00);
        check("mid_rst_hex1", HEX1, SEG_0);
        Reset = 1'b0; Run = 1'b0;
        step();
        do_div("post_rst", 8'd200, 8'd13, 8'd15, 8'd5, 1'b0);

        // Run held for 30 cycles with SW/Load noise during ITER
        Load = 1'b1; SW = 8'd100;
        step();
        Load = 1'b0; Run = 1'b1; SW = 8'd7;
        step();                          // edge k
        for (int i = 0; i < 29; i++) begin
            SW   = 8'($urandom_range(0, 255));
            Load = 1'($urandom_range(0, 1));
            step();
        end
        Load = 1'b0;
        check("hold_done", Done, 1'b1);
        check("hold_busy", Busy, 1'b0);
        check("hold_q",    Qval, 8'h0E);
        check("hold_a",    Aval, 8'h02);
        Run = 1'b0;
        step();
        check("hold_idle", Done, 1'b0);

        // Second divide reuses the previous quotient: 14 / 3 = 4 r 2
        Run = 1'b1; SW = 8'd3;
        step();
        check("second_busy", Busy, 1'b1);
        repeat (8) step();
        check("second_done", Done, 1'b1);
        check("second_q",    Qval, 8'h04);
        check("second_a",    Aval, 8'h02);
        Run = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
